// File: rtl/commit_pred_tx.sv
// Commit-side branch predictor feeder: queues resolved control-flow commits toward
// the predictor update port and raises a registered redirect on mispredictions.
module commit_pred_tx #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cm_valid,
  output logic                       cm_ready,
  input  logic [31:0]                cm_pc,
  input  logic                       cm_br,
  input  logic                       cm_jal,
  input  logic                       cm_taken,
  input  logic [31:0]                cm_target,
  input  logic                       cm_pred_taken,
  input  logic [31:0]                cm_pred_target,
  output logic                       upd_valid,
  input  logic                       upd_ready,
  output logic [31:0]                upd_pc,
  output logic [31:0]                upd_target,
  output logic                       upd_br,
  output logic                       upd_jal,
  output logic                       upd_taken,
  output logic                       mispredict,
  output logic [31:0]                redirect_pc,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [31:0]                ctl_count,
  output logic [31:0]                mispred_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   OCC_ONE = 1;
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);

  // Entry layout: {pc, target, br, jal, taken}
  logic [66:0]   mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          mispredict_q, mispredict_d;
  logic [31:0]   redirect_q, redirect_d;
  logic [31:0]   ctl_count_q, ctl_count_d;
  logic [31:0]   mispred_count_q, mispred_count_d;

  logic          push;
  logic          pop;
  logic          mis_det;
  logic [66:0]   head;

  assign cm_ready  = (occ_q != OCC_FULL);
  assign upd_valid = (occ_q != '0);
  assign push      = cm_valid && cm_ready && (cm_br || cm_jal);
  assign pop       = upd_valid && upd_ready;
  // Direction wrong, or taken to a different place than fetch assumed
  assign mis_det   = push && ((cm_taken != cm_pred_taken) ||
                              (cm_taken && (cm_target != cm_pred_target)));

  assign head       = mem_q[rd_ptr_q];
  assign upd_pc     = head[66:35];
  assign upd_target = head[34:3];
  assign upd_br     = head[2];
  assign upd_jal    = head[1];
  assign upd_taken  = head[0];

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    occ_d           = occ_q;
    ctl_count_d     = ctl_count_q;
    mispred_count_d = mispred_count_q;
    mispredict_d    = mis_det;
    redirect_d      = redirect_q;
    if (push) begin
      wr_ptr_d    = wr_ptr_q + PTR_ONE;
      ctl_count_d = ctl_count_q + 32'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      occ_d = occ_q + OCC_ONE;
    end else if (!push && pop) begin
      occ_d = occ_q - OCC_ONE;
    end
    if (mis_det) begin
      mispred_count_d = mispred_count_q + 32'd1;
      redirect_d      = cm_taken ? cm_target : (cm_pc + 32'd4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      occ_q           <= '0;
      mispredict_q    <= 1'b0;
      redirect_q      <= '0;
      ctl_count_q     <= '0;
      mispred_count_q <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      occ_q           <= occ_d;
      mispredict_q    <= mispredict_d;
      redirect_q      <= redirect_d;
      ctl_count_q     <= ctl_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= {cm_pc, cm_target, cm_br, cm_jal, cm_taken};
    end
  end

  assign mispredict    = mispredict_q;
  assign redirect_pc   = redirect_q;
  assign occupancy     = occ_q;
  assign ctl_count     = ctl_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: doc/commit_pred_tx.md
COMMIT_PRED_TX -- requirements
Module: commit_pred_tx

Interface
REQ-001 Parameter DEPTH, default 4, update-queue entries; power of two, at least 2.
REQ-002 clk  input  1  clock, all state on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cm_valid  input  1  ROB commit slot valid.
REQ-005 cm_ready  output  1  block can accept a commit this cycle.
REQ-006 cm_pc  input  32  committed instruction PC.
REQ-007 cm_br / cm_jal  input  1 each  conditional branch / JAL; never both high.
REQ-008 cm_taken  input  1  resolved direction; JAL always 1.
REQ-009 cm_target  input  32  resolved target address.
REQ-010 cm_pred_taken / cm_pred_target  input  1 / 32  fetch-time prediction carried by ROB.
REQ-011 upd_valid / upd_ready  output / input  1 each  handshake toward predictor update port.
REQ-012 upd_pc, upd_target  output  32 each  head entry PC and resolved target.
REQ-013 upd_br, upd_jal, upd_taken  output  1 each  head entry type and resolution.
REQ-014 mispredict  output  1  one-cycle redirect pulse.
REQ-015 redirect_pc  output  32  correct next PC, valid with mispredict.
REQ-016 occupancy  output  $clog2(DEPTH)+1  current queue entry count.
REQ-017 ctl_count, mispred_count  output  32 each  committed control-flow / mispredicted counters.

Function
REQ-018 Commit accepted when cm_valid && cm_ready; cm_ready SHALL equal (occupancy != DEPTH), no same-cycle dequeue bypass.
REQ-019 Accepted commit with cm_br || cm_jal SHALL be enqueued {pc, target, br, jal, taken}; others accepted and dropped, no state change.
REQ-020 Queue SHALL be circular FIFO, read/write pointers wrap DEPTH-1 -> 0, strict commit order.
REQ-021 upd_valid SHALL equal (occupancy != 0); upd_* SHALL show head entry, stable while upd_valid && !upd_ready.
REQ-022 Dequeue when upd_valid && upd_ready; pop visible next cycle.
REQ-023 Enqueue-to-upd_valid latency: 1 cycle (entry written at edge, visible after).
REQ-024 Simultaneous enqueue and dequeue: occupancy unchanged, both pointers advance.
REQ-025 Mispredict condition on accepted control commit: (cm_taken != cm_pred_taken) || (cm_taken && cm_target != cm_pred_target).
REQ-026 mispredict SHALL be registered: high exactly the cycle after the accepting edge, else 0.
REQ-027 redirect_pc SHALL be cm_target if cm_taken, else cm_pc + 4 (32-bit wrap), registered with mispredict; holds last value otherwise.
REQ-028 Mispredict detection SHALL be independent of queue state; enqueue still occurs on mispredicting commit.
REQ-029 ctl_count +1 per accepted control commit; mispred_count +1 per mispredict; both wrap 2^32-1 -> 0.
REQ-030 Commit arriving with cm_ready low SHALL be ignored; no enqueue, no count, no mispredict.
REQ-031 Back-to-back mispredicting commits SHALL produce consecutive mispredict pulses, each with its own redirect_pc.

Reset
REQ-032 rst high at edge: pointers, occupancy, ctl_count, mispred_count, mispredict, redirect_pc all 0; queue contents discarded.
REQ-033 Post-reset: upd_valid 0, cm_ready 1, upd_* don't-care while upd_valid 0.
REQ-034 rst SHALL win over simultaneous commit or dequeue; nothing from that cycle retained.

Verification
REQ-035 Single branch pc=0x100, taken=1, target=0x80, pred_taken=1, pred_target=0x80 -> next cycle upd_valid=1, upd_pc=0x100, upd_target=0x80, mispredict=0, ctl_count=1.
REQ-036 Branch pc=0x200, taken=0, pred_taken=1 -> next cycle mispredict=1, redirect_pc=0x204, mispred_count=1; pulse gone following cycle.
REQ-037 upd_ready=0, 4 JALs pc=0x0,0x4,0x8,0xC (DEPTH=4) -> occupancy=4, cm_ready=0, 5th commit ignored; upd_ready=1 -> drains 0x0..0xC in order over 4 cycles.
REQ-038 Occupancy 2, enqueue and dequeue same cycle -> occupancy stays 2, order preserved across pointer wrap after 6 total pushes.
REQ-039 Non-control commit (br=jal=0) pc=0x300 -> no enqueue, ctl_count unchanged, mispredict=0.
REQ-040 Queue at occupancy 3 with mispredict pending, rst asserted -> next cycle occupancy=0, upd_valid=0, mispredict=0, both counters 0.
